// File: rtl/analog_core_sequencer.sv
// analog_core_sequencer
// Conversion sequencer for a bank of analog channels (CSA + discriminator + SAR ADC).
// Each channel runs its own sample/strobe/convert/rearm sequence. Finished results
// are tagged with the channel number and merged round-robin into one output FIFO.
module analog_core_sequencer #(
    parameter int NUMCHANNELS    = 64,
    parameter int ADCBITS        = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int SAMPLE_CYCLES  = 2,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CHW = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1,
    localparam int DW  = 1 + CHW + ADCBITS
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [1:0]                     mode_i,
    input  logic [NUMCHANNELS-1:0]         channel_enable_i,
    input  logic [NUMCHANNELS-1:0]         hit_i,
    input  logic                           ext_trigger_i,
    input  logic [15:0]                    periodic_interval_i,
    input  logic [NUMCHANNELS-1:0]         done_i,
    input  logic [NUMCHANNELS*ADCBITS-1:0] dout_i,
    output logic [NUMCHANNELS-1:0]         sample_o,
    output logic [NUMCHANNELS-1:0]         strobe_o,
    output logic [NUMCHANNELS-1:0]         csa_reset_o,
    output logic [DW-1:0]                  fifo_data_o,
    output logic                           fifo_valid_o,
    input  logic                           fifo_ready_i,
    output logic [7:0]                     missed_count_o,
    output logic                           busy_o
);

    localparam int MAXCNT0 = (SAMPLE_CYCLES > RESET_CYCLES) ? SAMPLE_CYCLES : RESET_CYCLES;
    localparam int MAXCNT  = (MAXCNT0 > TIMEOUT_CYCLES) ? MAXCNT0 : TIMEOUT_CYCLES;
    localparam int CNTW    = $clog2(MAXCNT + 1);
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNTW-1:0] SAMPLE_LAST  = CNTW'(SAMPLE_CYCLES - 1);
    localparam logic [CNTW-1:0] RESET_LAST   = CNTW'(RESET_CYCLES - 1);
    localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]     FIFO_FULL    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CHW-1:0]  LAST_CHAN    = CHW'(NUMCHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_STROBE,
        S_CONVERT,
        S_PEND,
        S_RESET
    } chanState_t;

    chanState_t             state_q   [NUMCHANNELS];
    logic [CNTW-1:0]        cnt_q     [NUMCHANNELS];
    logic [ADCBITS:0]       word_q    [NUMCHANNELS];
    logic [NUMCHANNELS-1:0] sample_q;
    logic [NUMCHANNELS-1:0] strobe_q;
    logic [NUMCHANNELS-1:0] csaReset_q;

    logic [NUMCHANNELS-1:0] trigger;
    logic [NUMCHANNELS-1:0] idleVec;
    logic [NUMCHANNELS-1:0] pendVec;
    logic                   anyMiss;

    logic [15:0]            periodCnt_q;
    logic                   periodTick;

    logic [7:0]             missedCount_q;
    logic [7:0]             missedCount_d;

    logic [CHW-1:0]         rrPtr_q;
    logic [CHW-1:0]         rrPtr_d;
    logic [CHW-1:0]         grantIdx;
    logic                   grantValid;
    logic                   grantFire;
    logic [DW-1:0]          grantWord;
    int                     scanIdx;

    logic [DW-1:0]          fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]          wrPtr_q;
    logic [AW-1:0]          rdPtr_q;
    logic [AW:0]            fifoCount_q;
    logic [AW:0]            fifoCount_d;
    logic                   fifoNotEmpty;
    logic                   popFire;

    // Periodic tick fires on the last count of the interval; interval 0 never ticks.
    assign periodTick = (mode_i == 2'd2) && (periodic_interval_i != 16'd0) &&
                        (periodCnt_q == (periodic_interval_i - 16'd1));

    // Per-channel trigger request, gated by the channel enable and the trigger mode.
    always_comb begin
        trigger = '0;
        case (mode_i)
            2'd1:    trigger = channel_enable_i & hit_i;
            2'd2:    trigger = periodTick ? channel_enable_i : '0;
            2'd3:    trigger = ext_trigger_i ? channel_enable_i : '0;
            default: trigger = '0;
        endcase
    end

    // Status vectors used by the miss counter, the arbiter and the busy flag.
    always_comb begin
        idleVec = '0;
        pendVec = '0;
        for (int i = 0; i < NUMCHANNELS; i++) begin
            idleVec[i] = (state_q[i] == S_IDLE);
            pendVec[i] = (state_q[i] == S_PEND);
        end
    end

    assign anyMiss       = |(trigger & ~idleVec);
    assign missedCount_d = (anyMiss && (missedCount_q != 8'hFF)) ? missedCount_q + 8'd1
                                                                 : missedCount_q;

    assign fifoNotEmpty = (fifoCount_q != '0);
    assign popFire      = fifoNotEmpty && fifo_ready_i;

    // Round-robin scan: first pending channel at or after the pointer, wrapping around.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        scanIdx    = 0;
        for (int j = 0; j < NUMCHANNELS; j++) begin
            scanIdx = (int'(rrPtr_q) + j) % NUMCHANNELS;
            if (!grantValid && pendVec[scanIdx]) begin
                grantValid = 1'b1;
                grantIdx   = CHW'(scanIdx);
            end
        end
    end

    // A full FIFO only accepts a write when the consumer frees a slot in the same cycle.
    assign grantFire = grantValid && ((fifoCount_q != FIFO_FULL) || popFire);
    assign grantWord = {word_q[grantIdx][ADCBITS], grantIdx, word_q[grantIdx][ADCBITS-1:0]};
    assign rrPtr_d   = !grantFire ? rrPtr_q :
                       (grantIdx == LAST_CHAN) ? '0 : grantIdx + CHW'(1);

    always_comb begin
        fifoCount_d = fifoCount_q;
        if (grantFire && !popFire) begin
            fifoCount_d = fifoCount_q + (AW + 1)'(1);
        end else if (!grantFire && popFire) begin
            fifoCount_d = fifoCount_q - (AW + 1)'(1);
        end
    end

    // Channel sequencers; the analog control lines are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUMCHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                word_q[i]  <= '0;
            end
            sample_q   <= '0;
            strobe_q   <= '0;
            csaReset_q <= '0;
        end else begin
            for (int i = 0; i < NUMCHANNELS; i++) begin
                sample_q[i]   <= 1'b0;
                strobe_q[i]   <= 1'b0;
                csaReset_q[i] <= 1'b0;
                case (state_q[i])
                    S_IDLE: begin
                        if (trigger[i]) begin
                            state_q[i]  <= S_SAMPLE;
                            cnt_q[i]    <= '0;
                            sample_q[i] <= 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (cnt_q[i] == SAMPLE_LAST) begin
                            state_q[i]  <= S_STROBE;
                            cnt_q[i]    <= '0;
                            strobe_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i]    <= cnt_q[i] + CNTW'(1);
                            sample_q[i] <= 1'b1;
                        end
                    end
                    S_STROBE: begin
                        state_q[i] <= S_CONVERT;
                        cnt_q[i]   <= '0;
                    end
                    S_CONVERT: begin
                        if (done_i[i]) begin
                            state_q[i] <= S_PEND;
                            word_q[i]  <= {1'b0, dout_i[i*ADCBITS +: ADCBITS]};
                        end else if (cnt_q[i] == TIMEOUT_LAST) begin
                            state_q[i] <= S_PEND;
                            word_q[i]  <= {1'b1, {ADCBITS{1'b1}}};
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNTW'(1);
                        end
                    end
                    S_PEND: begin
                        if (grantFire && (grantIdx == CHW'(i))) begin
                            state_q[i]    <= S_RESET;
                            cnt_q[i]      <= '0;
                            csaReset_q[i] <= 1'b1;
                        end
                    end
                    S_RESET: begin
                        if (cnt_q[i] == RESET_LAST) begin
                            state_q[i] <= S_IDLE;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i]      <= cnt_q[i] + CNTW'(1);
                            csaReset_q[i] <= 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= S_IDLE;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Periodic counter runs only in periodic mode and restarts on every tick.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            periodCnt_q <= '0;
        end else if ((mode_i != 2'd2) || (periodic_interval_i == 16'd0) || periodTick) begin
            periodCnt_q <= '0;
        end else begin
            periodCnt_q <= periodCnt_q + 16'd1;
        end
    end

    // Shared bookkeeping: miss counter, arbiter pointer and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            missedCount_q <= '0;
            rrPtr_q       <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            fifoCount_q   <= '0;
        end else begin
            missedCount_q <= missedCount_d;
            rrPtr_q       <= rrPtr_d;
            fifoCount_q   <= fifoCount_d;
            if (grantFire) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popFire) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
        end
    end

    // FIFO storage needs no reset; the head word is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (grantFire) begin
            fifoMem_q[wrPtr_q] <= grantWord;
        end
    end

    assign sample_o       = sample_q;
    assign strobe_o       = strobe_q;
    assign csa_reset_o    = csaReset_q;
    assign fifo_valid_o   = fifoNotEmpty;
    assign fifo_data_o    = fifoNotEmpty ? fifoMem_q[rdPtr_q] : '0;
    assign missed_count_o = missedCount_q;
    assign busy_o         = (~&idleVec) || fifoNotEmpty;

endmodule

// File: tb/tb_analog_core_sequencer.sv
// tb_analog_core_sequencer
// Random stimulus against a timestamp-based reference of the channel sequences,
// round-robin arbitration and output FIFO.
module tb_analog_core_sequencer;

    localparam int N     = 64;
    localparam int AB    = 10;
    localparam int DEPTH = 16;
    localparam int SC    = 2;
    localparam int RC    = 4;
    localparam int TO    = 64;
    localparam int CHW   = 6;
    localparam int DW    = 1 + CHW + AB;

    localparam int P_IDLE   = 0;
    localparam int P_SAMPLE = 1;
    localparam int P_STROBE = 2;
    localparam int P_CONV   = 3;
    localparam int P_PEND   = 4;
    localparam int P_RESET  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic [N-1:0]      channelEnable;
    logic [N-1:0]      hit;
    logic              extTrigger;
    logic [15:0]       periodicInterval;
    logic [N-1:0]      done;
    logic [N*AB-1:0]   dout;
    logic [N-1:0]      sample;
    logic [N-1:0]      strobe;
    logic [N-1:0]      csaReset;
    logic [DW-1:0]     fifoData;
    logic              fifoValid;
    logic              fifoReady;
    logic [7:0]        missedCount;
    logic              busy;

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Reference state: each channel is described by when its trigger was accepted,
    // when its result became pending and when it was granted (-1 = not yet).
    int             trigT   [N];
    int             pendT   [N];
    int             grantT  [N];
    int             doneDly [N];
    logic [AB:0]    mWord   [N];
    logic [DW-1:0]  fq [$];
    int             rrPtr;
    int             perCnt;
    int             missed;
    int             cycleNo = 0;

    logic [1:0]     segMode;
    logic [N-1:0]   segEnable;
    int             segHitDen;
    int             segExtDen;
    logic [15:0]    segInterval;
    int             segReadyPct;

    analog_core_sequencer dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .mode_i              (mode),
        .channel_enable_i    (channelEnable),
        .hit_i               (hit),
        .ext_trigger_i       (extTrigger),
        .periodic_interval_i (periodicInterval),
        .done_i              (done),
        .dout_i              (dout),
        .sample_o            (sample),
        .strobe_o            (strobe),
        .csa_reset_o         (csaReset),
        .fifo_data_o         (fifoData),
        .fifo_valid_o        (fifoValid),
        .fifo_ready_i        (fifoReady),
        .missed_count_o      (missedCount),
        .busy_o              (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycleNo, observed, expected);
        end
    endtask

    function automatic int phaseOf(input int i, input int n);
        int k;
        if (trigT[i] < 0) return P_IDLE;
        if (grantT[i] >= 0) return (n <= grantT[i]) ? P_PEND : P_RESET;
        if (pendT[i] >= 0 && n >= pendT[i]) return P_PEND;
        k = n - trigT[i];
        if (k <= SC) return P_SAMPLE;
        if (k == SC + 1) return P_STROBE;
        return P_CONV;
    endfunction

    function automatic int pickDelay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return TO + 10;
        if (r == 1) return TO - 1;
        return int'($urandom_range(0, 12));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            trigT[i]  = -1;
            pendT[i]  = -1;
            grantT[i] = -1;
            mWord[i]  = '0;
        end
        fq.delete();
        rrPtr  = 0;
        perCnt = 0;
        missed = 0;
    endtask

    task automatic setSegment(input logic [1:0] m, input logic [N-1:0] en, input int hitDen,
                              input int extDen, input logic [15:0] interval, input int readyPct);
        segMode     = m;
        segEnable   = en;
        segHitDen   = hitDen;
        segExtDen   = extDen;
        segInterval = interval;
        segReadyPct = readyPct;
    endtask

    task automatic applyStimulus(input bit doReset);
        int ph;
        reset            = doReset;
        mode             = segMode;
        channelEnable    = segEnable;
        periodicInterval = segInterval;
        extTrigger       = (segExtDen > 0) && ($urandom_range(0, segExtDen - 1) == 0);
        fifoReady        = ($urandom_range(0, 99) < segReadyPct);
        for (int i = 0; i < N; i++) begin
            hit[i]           = (segHitDen > 0) && ($urandom_range(0, segHitDen - 1) == 0);
            dout[i*AB +: AB] = AB'($urandom);
            ph = phaseOf(i, cycleNo);
            if (ph == P_CONV) done[i] = ((cycleNo - (trigT[i] + SC + 2)) == doneDly[i]);
            else              done[i] = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic compareAll();
        logic [N-1:0] expSample, expStrobe, expReset;
        bit anyActive;
        int ph;
        expSample = '0;
        expStrobe = '0;
        expReset  = '0;
        anyActive = 1'b0;
        for (int i = 0; i < N; i++) begin
            ph = phaseOf(i, cycleNo);
            expSample[i] = (ph == P_SAMPLE);
            expStrobe[i] = (ph == P_STROBE);
            expReset[i]  = (ph == P_RESET);
            if (ph != P_IDLE) anyActive = 1'b1;
        end
        checkOutput("sample", 64'(sample), 64'(expSample));
        checkOutput("strobe", 64'(strobe), 64'(expStrobe));
        checkOutput("csa_reset", 64'(csaReset), 64'(expReset));
        checkOutput("fifo_valid", 64'(fifoValid), 64'(fq.size() != 0));
        checkOutput("fifo_data", 64'(fifoData), (fq.size() != 0) ? 64'(fq[0]) : 64'd0);
        checkOutput("missed_count", 64'(missedCount), 64'(missed));
        checkOutput("busy", 64'(busy), 64'(anyActive || (fq.size() != 0)));
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic stepModel();
        int n;
        int ph [N];
        int cv;
        int idx;
        logic [N-1:0] trig;
        logic [DW-1:0] pushWord;
        bit tick, anyMiss, pop, granted;
        n = cycleNo;
        for (int i = 0; i < N; i++) ph[i] = phaseOf(i, n);
        tick = (mode == 2'd2) && (periodicInterval != 16'd0) &&
               (perCnt == int'(periodicInterval) - 1);
        case (mode)
            2'd1:    trig = channelEnable & hit;
            2'd2:    trig = tick ? channelEnable : '0;
            2'd3:    trig = extTrigger ? channelEnable : '0;
            default: trig = '0;
        endcase
        anyMiss = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (trig[i] && ph[i] != P_IDLE) anyMiss = 1'b1;
        end
        if (anyMiss && missed < 255) missed++;
        for (int i = 0; i < N; i++) begin
            if (ph[i] == P_IDLE && trig[i]) begin
                trigT[i]   = n;
                pendT[i]   = -1;
                grantT[i]  = -1;
                doneDly[i] = pickDelay();
            end else if (ph[i] == P_CONV) begin
                cv = n - (trigT[i] + SC + 2);
                if (done[i]) begin
                    mWord[i] = {1'b0, dout[i*AB +: AB]};
                    pendT[i] = n + 1;
                end else if (cv == TO - 1) begin
                    mWord[i] = {1'b1, {AB{1'b1}}};
                    pendT[i] = n + 1;
                end
            end
        end
        pop = (fq.size() != 0) && fifoReady;
        granted = 1'b0;
        pushWord = '0;
        if (fq.size() < DEPTH || pop) begin
            for (int j = 0; j < N; j++) begin
                idx = (rrPtr + j) % N;
                if (!granted && ph[idx] == P_PEND) begin
                    granted   = 1'b1;
                    grantT[idx] = n;
                    pushWord  = {mWord[idx][AB], CHW'(idx), mWord[idx][AB-1:0]};
                    rrPtr     = (idx + 1) % N;
                end
            end
        end
        if (pop) void'(fq.pop_front());
        if (granted) fq.push_back(pushWord);
        if (mode != 2'd2 || periodicInterval == 16'd0 || tick) perCnt = 0;
        else perCnt = (perCnt + 1) % 65536;
        cycleNo++;
        for (int i = 0; i < N; i++) begin
            if (grantT[i] >= 0 && cycleNo > grantT[i] + RC) begin
                trigT[i]  = -1;
                pendT[i]  = -1;
                grantT[i] = -1;
            end
        end
    endtask

    task automatic runSegment(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            applyStimulus(1'b0);
            compareAll();
            stepModel();
        end
    endtask

    task automatic midReset();
        @(negedge clk);
        applyStimulus(1'b1);
        compareAll();
        modelReset();
        cycleNo++;
    endtask

    // Test sequence: trigger modes, FIFO backpressure, mid-run reset, final drain.
    initial begin
        reset            = 1'b1;
        mode             = 2'd0;
        channelEnable    = '0;
        hit              = '0;
        extTrigger       = 1'b0;
        periodicInterval = 16'd0;
        done             = '0;
        dout             = '0;
        fifoReady        = 1'b0;
        setSegment(2'd0, '0, 0, 0, 16'd0, 100);
        modelReset();
        repeat (2) @(posedge clk);

        setSegment(2'd1, {N{1'b1}}, 200, 0, 16'd0, 80);
        runSegment(400);
        setSegment(2'd1, {N{1'b1}}, 20, 0, 16'd0, 0);
        runSegment(300);
        setSegment(2'd1, {N{1'b1}}, 100, 0, 16'd0, 100);
        runSegment(200);
        setSegment(2'd2, 64'h3, 0, 0, 16'd100, 70);
        runSegment(350);
        setSegment(2'd2, {$urandom, $urandom}, 10, 0, 16'd37, 60);
        runSegment(300);
        setSegment(2'd3, {N{1'b1}}, 0, 5, 16'd0, 30);
        runSegment(30);
        midReset();
        setSegment(2'd3, {$urandom, $urandom}, 0, 40, 16'd0, 50);
        runSegment(300);
        setSegment(2'd0, {N{1'b1}}, 4, 4, 16'd5, 100);
        runSegment(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
